// File: rtl/pipe_pkg.sv
// Shared definitions for the issue-pipeline inter-stage registers.
//   pipe_state_e    : occupancy state of a skid register (EMPTY, MAIN, SKID_FULL)
//   lane_payload_t  : one lane of opaque payload at the default lane width
//   state_occupancy : number of entries held in a given state
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    MAIN      = 2'd1,
    SKID_FULL = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_DATA_W = 256;

  typedef logic [PIPE_DATA_W-1:0] lane_payload_t;

  // Entries held for each state; the unused encoding maps to zero.
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:     occ = 2'd0;
      MAIN:      occ = 2'd1;
      SKID_FULL: occ = 2'd2;
      default:   occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_bundle_reg.sv
// One LANES-wide bundle entry (per-lane valid + payload).
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : capture d_vld_i/d_data_i; lanes loaded invalid store zero payload
//   clr_lane_i   : zero selected lanes of the value written this edge (loaded or held)
//   clr_all_i    : zero the whole entry; overrides load and clr_lane_i
//   d_vld_i/d_data_i : incoming lane valids / payload (lane i at [i*DATA_W +: DATA_W])
//   q_vld_o/q_data_o : registered lane valids / payload
module pipe_bundle_reg
  import pipe_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    clr_all_i,
  input  logic [LANES-1:0]        clr_lane_i,
  input  logic [LANES-1:0]        d_vld_i,
  input  logic [LANES*DATA_W-1:0] d_data_i,
  output logic [LANES-1:0]        q_vld_o,
  output logic [LANES*DATA_W-1:0] q_data_o
);

  logic [LANES-1:0]        vld_q, vld_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;

  // Next entry value: load with bubble gating, then lane clears, then clear-all.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load_i) begin
      for (int i = 0; i < int'(LANES); i++) begin
        vld_d[i] = d_vld_i[i];
        data_d[i*DATA_W +: DATA_W] = d_vld_i[i] ? d_data_i[i*DATA_W +: DATA_W] : '0;
      end
    end else begin
      vld_d  = vld_q;
      data_d = data_q;
    end
    for (int i = 0; i < int'(LANES); i++) begin
      if (clr_lane_i[i]) begin
        vld_d[i] = 1'b0;
        data_d[i*DATA_W +: DATA_W] = '0;
      end else begin
        vld_d[i] = vld_d[i];
      end
    end
    if (clr_all_i) begin
      vld_d  = '0;
      data_d = '0;
    end else begin
      vld_d  = vld_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign q_vld_o  = vld_q;
  assign q_data_o = data_q;

endmodule

// File: rtl/issue_pipe_skid_reg.sv
// Inter-stage register for the multi-issue pipeline with optional 2-entry skid.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : upstream bundle handshake
//   in_lane_vld/in_data      : per-lane valid / payload of the incoming bundle
//   out_valid/out_ready      : downstream handshake; out_* come straight from the main entry
//   out_lane_vld/out_data    : per-lane valid / payload of the main entry
//   flush_lane               : zero lanes of the main entry at this edge
//   flush_all                : drop every entry at this edge (highest priority after rst)
//   occupancy                : entries held (0..2)
//   stall_cnt                : saturating count of out_valid & !out_ready cycles
module issue_pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  input  logic [LANES-1:0]        flush_lane,
  input  logic                    flush_all,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cnt
);

  pipe_state_e             state_q, state_d;
  logic                    out_valid_q;
  logic [1:0]              occupancy_q;
  logic [CNT_W-1:0]        stall_cnt_q;

  logic                    rdy_s, in_fire_s, out_fire_s;
  logic                    main_load_s, main_from_skid_s, main_drain_s;
  logic                    skid_load_s, skid_drain_s;
  logic [LANES-1:0]        main_vld_s, skid_vld_s, main_d_vld_s;
  logic [LANES*DATA_W-1:0] main_data_s, skid_data_s, main_d_data_s;

  // Acceptance: with a skid, ready depends only on state so it never sees out_ready.
  always_comb begin
    if (SKID != 0) begin
      rdy_s = (state_q != SKID_FULL);
    end else begin
      rdy_s = !out_valid_q | out_ready;
    end
  end

  assign in_ready   = rdy_s & !flush_all & !rst;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid_q & out_ready;

  // Entry control and next state.
  always_comb begin
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    main_drain_s     = 1'b0;
    skid_load_s      = 1'b0;
    skid_drain_s     = 1'b0;
    state_d          = state_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_s) begin
          main_load_s = 1'b1;
          state_d     = MAIN;
        end else begin
          state_d     = EMPTY;
        end
      end
      MAIN: begin
        if (in_fire_s & out_fire_s) begin
          main_load_s  = 1'b1;
          state_d      = MAIN;
        end else if (out_fire_s) begin
          main_drain_s = 1'b1;
          state_d      = EMPTY;
        end else if (in_fire_s && (SKID != 0)) begin
          skid_load_s  = 1'b1;
          state_d      = SKID_FULL;
        end else begin
          state_d      = MAIN;
        end
      end
      SKID_FULL: begin
        if (out_fire_s) begin
          main_load_s      = 1'b1;
          main_from_skid_s = 1'b1;
          skid_drain_s     = 1'b1;
          state_d          = MAIN;
        end else begin
          state_d          = SKID_FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush_all) begin
      state_d = EMPTY;
    end else begin
      state_d = state_d;
    end
  end

  // State with its registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      occupancy_q <= state_occupancy(state_d);
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign main_d_vld_s  = main_from_skid_s ? skid_vld_s  : in_lane_vld;
  assign main_d_data_s = main_from_skid_s ? skid_data_s : in_data;

  pipe_bundle_reg #(.LANES(LANES), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load_i     (main_load_s),
    .clr_all_i  (flush_all | main_drain_s),
    .clr_lane_i (flush_lane),
    .d_vld_i    (main_d_vld_s),
    .d_data_i   (main_d_data_s),
    .q_vld_o    (main_vld_s),
    .q_data_o   (main_data_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_bundle_reg #(.LANES(LANES), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (skid_load_s),
        .clr_all_i  (flush_all | skid_drain_s),
        .clr_lane_i ({LANES{1'b0}}),
        .d_vld_i    (in_lane_vld),
        .d_data_i   (in_data),
        .q_vld_o    (skid_vld_s),
        .q_data_o   (skid_data_s)
      );
    end else begin : g_no_skid
      assign skid_vld_s  = '0;
      assign skid_data_s = '0;
    end
  endgenerate

  assign out_valid    = out_valid_q;
  assign out_lane_vld = main_vld_s;
  assign out_data     = main_data_s;
  assign occupancy    = occupancy_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_issue_pipe_skid_reg.sv
module tb_issue_pipe_skid_reg;

  localparam int unsigned LANES = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // skid instance
  logic        in_valid, in_ready, out_valid, out_ready, flush_all;
  logic [1:0]  in_lane_vld, out_lane_vld, flush_lane, occupancy;
  logic [31:0] in_data, out_data;
  logic [3:0]  stall_cnt;
  // single-entry instance
  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_flush_all;
  logic [1:0]  z_in_lane_vld, z_out_lane_vld, z_flush_lane, z_occupancy;
  logic [31:0] z_in_data, z_out_data;
  logic [3:0]  z_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  issue_pipe_skid_reg #(.LANES(LANES), .DATA_W(DW), .SKID(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_lane_vld(in_lane_vld), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_lane_vld(out_lane_vld), .out_data(out_data),
    .out_ready(out_ready), .flush_lane(flush_lane), .flush_all(flush_all),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  issue_pipe_skid_reg #(.LANES(LANES), .DATA_W(DW), .SKID(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_lane_vld(z_in_lane_vld), .in_data(z_in_data),
    .in_ready(z_in_ready), .out_valid(z_out_valid), .out_lane_vld(z_out_lane_vld), .out_data(z_out_data),
    .out_ready(z_out_ready), .flush_lane(z_flush_lane), .flush_all(z_flush_all),
    .occupancy(z_occupancy), .stall_cnt(z_stall_cnt)
  );

  typedef struct {
    logic        v;
    logic [1:0]  lv;
    logic [31:0] d;
    logic        ordy;
    logic [1:0]  fl;
    logic        fa;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_olv;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
    logic [3:0]  e_st;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input logic [1:0] lv, input logic [31:0] d,
                              input logic ordy, input logic [1:0] fl, input logic fa,
                              input logic ir, input logic ov, input logic [1:0] olv,
                              input logic [31:0] od, input logic [1:0] occ, input logic [3:0] st);
    vec_t r;
    r.v = v; r.lv = lv; r.d = d; r.ordy = ordy; r.fl = fl; r.fa = fa;
    r.e_ir = ir; r.e_ov = ov; r.e_olv = olv; r.e_od = od; r.e_occ = occ; r.e_st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] d,
                       input logic ordy, input logic [1:0] fl, input logic fa);
    in_valid = v; in_lane_vld = lv; in_data = d; out_ready = ordy; flush_lane = fl; flush_all = fa;
  endtask

  task automatic drive0(input logic v, input logic [31:0] d, input logic ordy, input logic fa);
    z_in_valid = v; z_in_lane_vld = 2'b11; z_in_data = d; z_out_ready = ordy;
    z_flush_lane = 2'b00; z_flush_all = fa;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // streaming
    tbl[0]  = mk(1'b1, 2'b11, 32'h00B0_00A0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00B0_00A0, 2'd1, 4'd0);
    tbl[1]  = mk(1'b1, 2'b11, 32'h00B1_00A1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00B1_00A1, 2'd1, 4'd0);
    tbl[2]  = mk(1'b1, 2'b11, 32'h00B2_00A2, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00B2_00A2, 2'd1, 4'd0);
    tbl[3]  = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'd0, 4'd0);
    // skid fill and drain: A, B in; C refused
    tbl[4]  = mk(1'b1, 2'b11, 32'h00C1_00C0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00C1_00C0, 2'd1, 4'd0);
    tbl[5]  = mk(1'b1, 2'b11, 32'h00D1_00D0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00C1_00C0, 2'd2, 4'd1);
    tbl[6]  = mk(1'b1, 2'b11, 32'h00E1_00E0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00C1_00C0, 2'd2, 4'd2);
    tbl[7]  = mk(1'b0, 2'b00, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00C1_00C0, 2'd2, 4'd3);
    tbl[8]  = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00D1_00D0, 2'd1, 4'd3);
    tbl[9]  = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'd0, 4'd3);
    // lane flush on held main while skid fills, then skid moves in untouched
    tbl[10] = mk(1'b1, 2'b11, 32'h11F1_11F0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h11F1_11F0, 2'd1, 4'd3);
    tbl[11] = mk(1'b1, 2'b11, 32'h22F1_22F0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_11F0, 2'd2, 4'd4);
    tbl[12] = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 32'h22F1_22F0, 2'd1, 4'd4);
    // lane flush applied to the value being loaded
    tbl[13] = mk(1'b1, 2'b11, 32'h33F1_33F0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 2'b10, 32'h33F1_0000, 2'd1, 4'd4);
    // flush_all in SKID_FULL with out_ready=1
    tbl[14] = mk(1'b1, 2'b11, 32'h44F1_44F0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 32'h33F1_0000, 2'd2, 4'd5);
    tbl[15] = mk(1'b1, 2'b11, 32'h99F1_99F0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 2'd0, 4'd5);
    tbl[16] = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'd0, 4'd5);
    tbl[17] = mk(1'b1, 2'b11, 32'h55F1_55F0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 32'h55F1_55F0, 2'd1, 4'd5);
    // bubble gating, including an all-invalid bundle that must still drain
    tbl[18] = mk(1'b1, 2'b01, 32'hFFFF_0066, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_0066, 2'd1, 4'd5);
    tbl[19] = mk(1'b1, 2'b10, 32'h0077_FFFF, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 32'h0077_0000, 2'd1, 4'd5);
    tbl[20] = mk(1'b1, 2'b00, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 2'd1, 4'd5);
    tbl[21] = mk(1'b0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0000, 2'd0, 4'd5);

    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0);
    drive0(1'b0, 32'h0, 1'b0, 1'b0);

    // reset for two cycles
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].lv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].fa);
      #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_lane_vld", i), 32'(out_lane_vld), 32'(tbl[i].e_olv));
      chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_st));
    end

    // stall counter saturation
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("sat_rst_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b11, 32'h0123_4567, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("sat_load_stall", 32'(stall_cnt), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 1'b0, 2'b00, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("sat_stall_k%0d", k), 32'(stall_cnt), (k < 15) ? 32'(k) : 32'd15);
    end

    // reset while SKID_FULL and out_ready=1 drops both entries
    @(negedge clk);
    drive(1'b1, 2'b11, 32'h0BAD_0BAD, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("rstmid_fill_occ", 32'(occupancy), 32'h2);
    @(negedge clk);
    drive(1'b1, 2'b11, 32'h0C0C_0C0C, 1'b1, 2'b00, 1'b0);
    rst = 1'b1;
    #1 chk("rstmid_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("rstmid_occ", 32'(occupancy), 32'h0);
    chk("rstmid_out_valid", 32'(out_valid), 32'h0);
    chk("rstmid_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b1, 2'b00, 1'b0);
    @(posedge clk); #1;
    chk("rstmid_after_out_valid", 32'(out_valid), 32'h0);
    chk("rstmid_after_out_data", out_data, 32'h0);

    // single-entry variant: ready = !out_valid | out_ready
    @(negedge clk);
    drive0(1'b1, 32'h0001_0002, 1'b0, 1'b0);
    #1 chk("s0_a_in_ready", 32'(z_in_ready), 32'h1);
    @(posedge clk); #1;
    chk("s0_a_out_data", z_out_data, 32'h0001_0002);
    chk("s0_a_occ", 32'(z_occupancy), 32'h1);
    @(negedge clk);
    drive0(1'b1, 32'h0003_0004, 1'b0, 1'b0);
    #1 chk("s0_b_in_ready", 32'(z_in_ready), 32'h0);
    @(posedge clk); #1;
    chk("s0_b_out_data", z_out_data, 32'h0001_0002);
    chk("s0_b_occ", 32'(z_occupancy), 32'h1);
    chk("s0_b_stall", 32'(z_stall_cnt), 32'h1);
    @(negedge clk);
    drive0(1'b1, 32'h0003_0004, 1'b1, 1'b0);
    #1 chk("s0_c_in_ready", 32'(z_in_ready), 32'h1);
    @(posedge clk); #1;
    chk("s0_c_out_data", z_out_data, 32'h0003_0004);
    @(negedge clk);
    drive0(1'b1, 32'h0005_0006, 1'b1, 1'b1);
    #1 chk("s0_d_in_ready", 32'(z_in_ready), 32'h0);
    @(posedge clk); #1;
    chk("s0_d_out_valid", 32'(z_out_valid), 32'h0);
    chk("s0_d_occ", 32'(z_occupancy), 32'h0);
    @(negedge clk);
    drive0(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("s0_e_out_valid", 32'(z_out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
